// File: rtl/bus_addr_decoder.sv
// Registered bus address decoder: selects one of NUM_SLV slaves by an address field,
// runs the request/response handshake and reports unmapped, disabled or timed-out accesses.
module bus_addr_decoder #(
  parameter int unsigned NUM_SLV = 6,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SEL_MSB = 31,
  parameter int unsigned SEL_LSB = 28,
  parameter logic [NUM_SLV*(SEL_MSB-SEL_LSB+1)-1:0] SLV_IDS =
    {4'h9, 4'h8, 4'h6, 4'h5, 4'h4, 4'h3},
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m_valid,
  output logic                      m_ready,
  input  logic [ADDR_W-1:0]         m_addr,
  input  logic [NUM_SLV-1:0]        slv_en,
  output logic [NUM_SLV-1:0]        s_valid,
  input  logic [NUM_SLV-1:0]        s_ready,
  input  logic [NUM_SLV-1:0]        s_resp_valid,
  input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
  output logic                      m_resp_valid,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_err,
  output logic [ADDR_W-1:0]         err_addr,
  output logic [7:0]                err_cnt
);

  localparam int unsigned FW = SEL_MSB - SEL_LSB + 1;
  localparam int unsigned SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [SW-1:0]     sel_q;
  logic [TW-1:0]     timer;

  logic [FW-1:0]     field;
  logic [SW-1:0]     hit_idx;
  logic              hit_any;
  logic              sel_ready;
  logic              sel_resp;
  logic              resp_hit;
  logic              expire;
  logic [DATA_W-1:0] sel_rdata;

  // Priority decode of the incoming address; the lowest matching enabled slave wins
  always_comb begin
    field   = m_addr[SEL_MSB:SEL_LSB];
    hit_idx = '0;
    hit_any = 1'b0;
    for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
      if (slv_en[i] && (field == SLV_IDS[i*FW +: FW])) begin
        hit_idx = SW'(i);
        hit_any = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ready = s_ready[sel_q];
    sel_resp  = s_resp_valid[sel_q];
    sel_rdata = s_rdata[DATA_W*int'(sel_q) +: DATA_W];
    resp_hit  = ((state == RESP) && sel_resp) ||
                ((state == REQ) && sel_ready && sel_resp);
    expire    = (TIMEOUT != 0) && (timer == T_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      m_ready      <= 1'b0;
      s_valid      <= '0;
      m_resp_valid <= 1'b0;
      m_rdata      <= '0;
      m_err        <= 1'b0;
      err_addr     <= '0;
      err_cnt      <= '0;
      addr_q       <= '0;
      sel_q        <= '0;
      timer        <= '0;
    end else begin
      m_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (m_valid && m_ready) begin
            addr_q  <= m_addr;
            m_ready <= 1'b0;
            timer   <= '0;
            if (hit_any) begin
              sel_q   <= hit_idx;
              s_valid <= NUM_SLV'(1) << hit_idx;
              state   <= REQ;
            end else begin
              state <= ERR;
            end
          end else begin
            m_ready <= 1'b1;
          end
        end
        REQ, RESP: begin
          timer <= timer + TW'(1);
          // A response arriving on the expiry cycle still completes normally
          if (resp_hit) begin
            s_valid      <= '0;
            m_resp_valid <= 1'b1;
            m_rdata      <= sel_rdata;
            m_err        <= 1'b0;
            m_ready      <= 1'b1;
            state        <= IDLE;
          end else if (expire) begin
            s_valid <= '0;
            state   <= ERR;
          end else if ((state == REQ) && sel_ready) begin
            s_valid <= '0;
            state   <= RESP;
          end
        end
        ERR: begin
          m_resp_valid <= 1'b1;
          m_rdata      <= '0;
          m_err        <= 1'b1;
          err_addr     <= addr_q;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          m_ready      <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
